// File: rtl/soc_sonhamos_pkg.sv
// SoC-level constants and types shared by the CGRA slave bridge and its response buffer.
package soc_sonhamos_pkg;

    localparam logic [31:0] EXT_SLAVE_START_ADDRESS = 32'hF000_0000;
    localparam logic [31:0] CGRA_START_ADDRESS      = EXT_SLAVE_START_ADDRESS;

    localparam int unsigned CGRA_MEM_AW       = 16;
    localparam int unsigned CGRA_MAX_OUTST    = 2;
    localparam int unsigned CGRA_ERR_CNT_W    = 8;
    localparam logic [31:0] CGRA_UNMAPPED_RDATA = 32'h0;

    typedef struct packed {
        logic        mapped;
        logic        filled;
        logic [31:0] data;
    } cgra_resp_entry_t;

endpackage

// File: rtl/cgra_obi_resp_buf.sv
// In-order OBI response buffer: push on grant, fill from memory responses, pop one per cycle.
module cgra_obi_resp_buf
    import soc_sonhamos_pkg::*;
#(
    parameter int unsigned DEPTH = CGRA_MAX_OUTST
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        push_mapped_i,
    input  logic        fill_i,
    input  logic [31:0] fill_data_i,
    output logic        space_c_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    cgra_resp_entry_t [DEPTH-1:0] ent_q, ent_d;
    ptr_t                         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         rvalid_q, rvalid_d;
    logic [31:0]                  rdata_q, rdata_d;

    ptr_t             fill_ptr, scan_ptr;
    logic             fill_hit, head_bypass, pop;
    cgra_resp_entry_t head;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign space_c_o = (cnt_q < CNT_W'(DEPTH));
    assign head      = ent_q[rd_ptr_q];

    // Fill pointer: oldest occupied entry that is mapped and still waiting for data.
    always_comb begin
        fill_hit = 1'b0;
        fill_ptr = rd_ptr_q;
        scan_ptr = rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!fill_hit && (CNT_W'(i) < cnt_q) &&
                ent_q[scan_ptr].mapped && !ent_q[scan_ptr].filled) begin
                fill_hit = 1'b1;
                fill_ptr = scan_ptr;
            end
            scan_ptr = ptr_inc(scan_ptr);
        end
    end

    // A memory response landing on the head entry is returned straight away.
    assign head_bypass = fill_i && fill_hit && (fill_ptr == rd_ptr_q);
    assign pop         = (cnt_q != '0) && (head.filled || head_bypass);

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_i) - CNT_W'(pop);
        rvalid_d = pop;
        rdata_d  = rdata_q;
        if (fill_i && fill_hit) begin
            ent_d[fill_ptr].filled = 1'b1;
            ent_d[fill_ptr].data   = fill_data_i;
        end
        if (push_i) begin
            ent_d[wr_ptr_q].mapped = push_mapped_i;
            ent_d[wr_ptr_q].filled = ~push_mapped_i;
            ent_d[wr_ptr_q].data   = CGRA_UNMAPPED_RDATA;
            wr_ptr_d               = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rdata_d  = head_bypass ? fill_data_i : head.data;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/cgra_obi_slave_bridge.sv
// OBI slave for the CGRA crossbar window: decodes offsets, forwards mapped accesses
// to the CGRA memory port, answers unmapped ones locally and counts them.
module cgra_obi_slave_bridge
    import soc_sonhamos_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CGRA_START_ADDRESS,
    parameter int unsigned MEM_AW    = CGRA_MEM_AW,
    parameter int unsigned MAX_OUTST = CGRA_MAX_OUTST,
    parameter int unsigned ERR_CNT_W = CGRA_ERR_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [MEM_AW-1:0]    mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 err_o,
    input  logic                 err_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [32:0] MAP_BYTES = 33'(4) << MEM_AW;

    logic [31:0]          offset;
    logic                 mapped, space, err_evt;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign offset = addr_i - BASE_ADDR;
    assign mapped = ({1'b0, offset} < MAP_BYTES);

    assign mem_req_o   = req_i & mapped & space;
    assign gnt_o       = req_i & space & (mapped ? mem_gnt_i : 1'b1);
    assign mem_we_o    = we_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;
    assign mem_addr_o  = offset[MEM_AW+1:2];

    cgra_obi_resp_buf #(
        .DEPTH (MAX_OUTST)
    ) u_resp_buf (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (gnt_o),
        .push_mapped_i (mapped),
        .fill_i        (mem_rvalid_i),
        .fill_data_i   (mem_rdata_i),
        .space_c_o     (space),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o)
    );

    // Sticky error flag and saturating counter; a clear coinciding with an error restarts at 1.
    assign err_evt = gnt_o & ~mapped;

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (err_clr_i) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
        if (err_evt) begin
            err_d = 1'b1;
            if (err_clr_i) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule
